// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard, flush and halt-drain sequencer (optional perf counters: HAZ_PERF_EN)
module pipe_hazard_ctrl #(
    parameter int ADDR_W    = 5,
    parameter int DRAIN_MAX = 4,
    parameter int R0_ZERO   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_rs1_en,
    input  logic              id_rs2_en,
    input  logic              id_halt,
    input  logic [ADDR_W-1:0] exe_rd,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              exe_wen,
    input  logic              mem_wen,
    input  logic              wb_wen,
    input  logic              exe_br_taken,
    input  logic              wb_halt,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idexe_bubble,
    output logic              halt,
    output logic              drain_err,
    output logic [2:0]        state,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       flush_count
);

    localparam int CNT_W = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_STALL  = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t             state_q;
    state_t             next_state;
    logic [CNT_W-1:0]   drain_cnt;
    logic               rs1_zero;
    logic               rs2_zero;
    logic               rs1_hit;
    logic               rs2_hit;
    logic               hazard;
    logic               haz_stall;
    logic               br_accept;
    logic               drain_expire;

    // Register 0 never carries a dependency when it is hardwired to zero
    assign rs1_zero = (R0_ZERO != 0) && (id_rs1 == '0);
    assign rs2_zero = (R0_ZERO != 0) && (id_rs2 == '0);

    // WB is a hazard source too: the register file does not bypass a same-cycle write
    assign rs1_hit = id_rs1_en && !rs1_zero &&
                     ((exe_wen && (id_rs1 == exe_rd)) ||
                      (mem_wen && (id_rs1 == mem_rd)) ||
                      (wb_wen  && (id_rs1 == wb_rd)));
    assign rs2_hit = id_rs2_en && !rs2_zero &&
                     ((exe_wen && (id_rs2 == exe_rd)) ||
                      (mem_wen && (id_rs2 == mem_rd)) ||
                      (wb_wen  && (id_rs2 == wb_rd)));
    assign hazard  = id_valid && (rs1_hit || rs2_hit);

    assign state = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state and pipeline control outputs
    always_comb begin
        next_state   = state_q;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        haz_stall    = 1'b0;
        br_accept    = 1'b0;
        drain_expire = 1'b0;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (exe_br_taken) begin
                    // ID is being killed, so any hazard it shows is irrelevant
                    ifid_flush   = 1'b1;
                    idexe_bubble = 1'b1;
                    br_accept    = 1'b1;
                    next_state   = ST_FLUSH;
                end else if (hazard) begin
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idexe_bubble = 1'b1;
                    haz_stall    = 1'b1;
                    next_state   = ST_STALL;
                end else if (id_valid && id_halt) begin
                    // HALT moves on to EXE; nothing younger is fetched behind it
                    pc_stall     = 1'b1;
                    ifid_flush   = 1'b1;
                    next_state   = ST_DRAIN;
                end else begin
                    next_state   = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // ID holds the flushed NOP and EXE a bubble: nothing to act on
                next_state = ST_RUN;
            end
            ST_DRAIN: begin
                pc_stall     = 1'b1;
                ifid_flush   = 1'b1;
                idexe_bubble = 1'b1;
                if (wb_halt) begin
                    next_state = ST_HALTED;
                end else if (exe_br_taken) begin
                    // An older branch redirected the program: the halt was speculative
                    pc_stall   = 1'b0;
                    br_accept  = 1'b1;
                    next_state = ST_FLUSH;
                end else if (drain_cnt <= CNT_W'(1)) begin
                    drain_expire = 1'b1;
                    next_state   = ST_HALTED;
                end
            end
            ST_HALTED: begin
                pc_stall     = 1'b1;
                ifid_stall   = 1'b1;
                idexe_bubble = 1'b1;
                next_state   = ST_HALTED;
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
        // A halt retiring without a tracked drain still stops the machine
        if (wb_halt && (state_q != ST_DRAIN) && (state_q != ST_HALTED)) begin
            next_state = ST_HALTED;
        end
    end

    // Drain watchdog: loaded on entry to DRAIN, counts down while draining
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if ((next_state == ST_DRAIN) && (state_q != ST_DRAIN)) begin
            drain_cnt <= CNT_W'(DRAIN_MAX);
        end else if ((state_q == ST_DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - CNT_W'(1);
        end
    end

    // Registered halt and sticky watchdog error
    always_ff @(posedge clk) begin
        if (rst) begin
            halt      <= 1'b0;
            drain_err <= 1'b0;
        end else begin
            halt      <= (next_state == ST_HALTED);
            drain_err <= drain_err | drain_expire;
        end
    end

`ifdef HAZ_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    // Saturating event counters for hazard stalls and accepted branch flushes
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'h0000;
            flush_q <= 16'h0000;
        end else begin
            if (haz_stall && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'h0001;
            end
            if (br_accept && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'h0001;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 16'h0000;
    assign flush_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - table-driven and sequence checks for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_en;
    logic        id_rs2_en;
    logic        id_halt;
    logic [4:0]  exe_rd;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic        exe_wen;
    logic        mem_wen;
    logic        wb_wen;
    logic        exe_br_taken;
    logic        wb_halt;
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idexe_bubble;
    logic        halt;
    logic        drain_err;
    logic [2:0]  state;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipe_hazard_ctrl #(.ADDR_W(5), .DRAIN_MAX(4), .R0_ZERO(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_en    (id_rs1_en),
        .id_rs2_en    (id_rs2_en),
        .id_halt      (id_halt),
        .exe_rd       (exe_rd),
        .mem_rd       (mem_rd),
        .wb_rd        (wb_rd),
        .exe_wen      (exe_wen),
        .mem_wen      (mem_wen),
        .wb_wen       (wb_wen),
        .exe_br_taken (exe_br_taken),
        .wb_halt      (wb_halt),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .ifid_flush   (ifid_flush),
        .idexe_bubble (idexe_bubble),
        .halt         (halt),
        .drain_err    (drain_err),
        .state        (state),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       rs1_en;
        logic [4:0] rs2;
        logic       rs2_en;
        logic       hlt;
        logic [4:0] erd;
        logic       ewen;
        logic [4:0] mrd;
        logic       mwen;
        logic [4:0] wrd;
        logic       wwen;
        logic       br;
        logic [3:0] exp_out;
        logic [2:0] exp_next;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic rs1_en,
                                input logic [4:0] rs2, input logic rs2_en, input logic hlt,
                                input logic [4:0] erd, input logic ewen, input logic [4:0] mrd,
                                input logic mwen, input logic [4:0] wrd, input logic wwen,
                                input logic br, input logic [3:0] exp_out, input logic [2:0] exp_next);
        vec_t v;
        v.valid = valid; v.rs1 = rs1; v.rs1_en = rs1_en; v.rs2 = rs2; v.rs2_en = rs2_en;
        v.hlt = hlt; v.erd = erd; v.ewen = ewen; v.mrd = mrd; v.mwen = mwen;
        v.wrd = wrd; v.wwen = wwen; v.br = br; v.exp_out = exp_out; v.exp_next = exp_next;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_en = 1'b0; id_rs2_en = 1'b0;
        id_halt = 1'b0; exe_rd = '0; mem_rd = '0; wb_rd = '0; exe_wen = 1'b0;
        mem_wen = 1'b0; wb_wen = 1'b0; exe_br_taken = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [3:0] outs();
        return {pc_stall, ifid_stall, ifid_flush, idexe_bubble};
    endfunction

    initial begin
        rst = 1'b0;
        clear_inputs();

        //            valid rs1  en   rs2  en   hlt  erd  ew   mrd  mw   wrd  ww   br   out      next
        vecs[0]  = mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 3'd0);
        vecs[1]  = mk(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b1101, 3'd1);
        vecs[2]  = mk(1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 4'b1101, 3'd1);
        vecs[3]  = mk(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 4'b1101, 3'd1);
        vecs[4]  = mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 4'b0000, 3'd0);
        vecs[5]  = mk(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 3'd0);
        vecs[6]  = mk(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 3'd0);
        vecs[7]  = mk(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 1'b0, 5'd4, 1'b0, 5'd3, 1'b0, 1'b0, 4'b0000, 3'd0);
        vecs[8]  = mk(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b0011, 3'd2);
        vecs[9]  = mk(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 4'b1010, 3'd3);
        vecs[10] = mk(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 4'b1101, 3'd1);
        vecs[11] = mk(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 5'd4, 1'b1, 5'd31, 1'b1, 1'b0, 4'b0000, 3'd0);

        // reset state
        do_reset();
        check("reset_state", state, 3'd0);
        check("reset_halt", halt, 1'b0);
        check("reset_drain_err", drain_err, 1'b0);
        check("reset_outs", outs(), 4'b0000);
        check("reset_stall_cycles", stall_cycles, 16'h0000);

        // single-cycle decisions from RUN
        for (int i = 0; i < 12; i++) begin
            do_reset();
            id_valid = vecs[i].valid; id_rs1 = vecs[i].rs1; id_rs1_en = vecs[i].rs1_en;
            id_rs2 = vecs[i].rs2; id_rs2_en = vecs[i].rs2_en; id_halt = vecs[i].hlt;
            exe_rd = vecs[i].erd; exe_wen = vecs[i].ewen; mem_rd = vecs[i].mrd;
            mem_wen = vecs[i].mwen; wb_rd = vecs[i].wrd; wb_wen = vecs[i].wwen;
            exe_br_taken = vecs[i].br;
            #1;
            check($sformatf("vec%0d_outs", i), outs(), vecs[i].exp_out);
            tick();
            check($sformatf("vec%0d_next", i), state, vecs[i].exp_next);
        end

        // producer of r3 walks EXE -> MEM -> WB -> gone
        do_reset();
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_en = 1'b1;
        exe_rd = 5'd3; exe_wen = 1'b1;
        #1; check("stall_c0_outs", outs(), 4'b1101); tick(); check("stall_c0_state", state, 3'd1);
        exe_wen = 1'b0; mem_rd = 5'd3; mem_wen = 1'b1;
        #1; check("stall_c1_outs", outs(), 4'b1101); tick(); check("stall_c1_state", state, 3'd1);
        mem_wen = 1'b0; wb_rd = 5'd3; wb_wen = 1'b1;
        #1; check("stall_c2_outs", outs(), 4'b1101); tick(); check("stall_c2_state", state, 3'd1);
        wb_wen = 1'b0;
        #1; check("stall_c3_outs", outs(), 4'b0000); tick(); check("stall_c3_state", state, 3'd0);
`ifdef HAZ_PERF_EN
        check("stall_cycles_3", stall_cycles, 16'd3);
`else
        check("stall_cycles_off", stall_cycles, 16'd0);
`endif

        // branch beats hazard, then FLUSH ignores everything for one cycle
        do_reset();
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_en = 1'b1; exe_rd = 5'd3; exe_wen = 1'b1;
        exe_br_taken = 1'b1;
        #1; check("br_outs", outs(), 4'b0011); tick(); check("br_state", state, 3'd2);
        #1; check("flush_outs", outs(), 4'b0000); tick(); check("flush_next", state, 3'd0);
`ifdef HAZ_PERF_EN
        check("flush_count_1", flush_count, 16'd1);
`endif

        // halt drain completes when wb_halt arrives 3 cycles after id_halt
        do_reset();
        id_valid = 1'b1; id_halt = 1'b1;
        #1; check("halt_id_outs", outs(), 4'b1010); tick();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("drain_state_%0d", c), state, 3'd3);
            check($sformatf("drain_outs_%0d", c), outs(), 4'b1011);
            check($sformatf("drain_halt_%0d", c), halt, 1'b0);
            if (c == 2) wb_halt = 1'b1;
            tick();
        end
        wb_halt = 1'b0;
        check("halted_state", state, 3'd4);
        check("halted_halt", halt, 1'b1);
        check("halted_no_err", drain_err, 1'b0);
        exe_br_taken = 1'b1; id_valid = 1'b1; id_halt = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("halted_hold_%0d", c), {halt, state}, {1'b1, 3'd4});
        end
        check("halted_outs", outs(), 4'b1101);
        clear_inputs();

        // watchdog expiry after DRAIN_MAX cycles, then reset from HALTED
        do_reset();
        id_valid = 1'b1; id_halt = 1'b1; tick(); clear_inputs();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("wd_state_%0d", c), state, 3'd3);
            check($sformatf("wd_err_%0d", c), drain_err, 1'b0);
            tick();
        end
        check("wd_halted", state, 3'd4);
        check("wd_err", drain_err, 1'b1);
        check("wd_halt", halt, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_from_halted_state", state, 3'd0);
        check("rst_from_halted_halt", halt, 1'b0);
        check("rst_from_halted_err", drain_err, 1'b0);
        check("rst_from_halted_stall_cycles", stall_cycles, 16'h0000);

        // older branch abandons a drain in progress
        do_reset();
        id_valid = 1'b1; id_halt = 1'b1; tick(); clear_inputs();
        exe_br_taken = 1'b1;
        #1; check("drain_br_outs", outs(), 4'b0011); tick(); check("drain_br_state", state, 3'd2);
        exe_br_taken = 1'b0; tick(); check("drain_br_run", state, 3'd0);
        check("drain_br_halt", halt, 1'b0);

        // reset in the middle of a drain
        do_reset();
        id_valid = 1'b1; id_halt = 1'b1; tick(); clear_inputs();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_drain", state, 3'd0);

        // wb_halt outside DRAIN goes straight to HALTED
        do_reset();
        wb_halt = 1'b1; tick(); wb_halt = 1'b0;
        check("wb_halt_run_state", state, 3'd4);
        check("wb_halt_run_halt", halt, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
